seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Parametrised multiplexed seven-segment scan controller; successor to the fixed six-digit driver in the CPU display path. Drives DIGITS common-anode/cathode digits with decimal points, per-digit blanking, leading-zero suppression and PWM brightness. It accepts new display frames through a valid/ready handshake into a shadow buffer committed only at frame boundaries, so digits never tear mid-scan. It sits between the CPU debug/register-readout logic and the board's segment/select pins.

## Interface
- DIGITS, 6: number of digits, 2..8.
- SCAN_DIV, 65536: clocks per digit slot; power of two, at least 2**BRIGHT_W.
- BRIGHT_W, 4: brightness control width.
- SEG_ACTIVE_LOW, 1: 1 means seg/dp are driven 0 = lit.
- SEL_ACTIVE_LOW, 1: 1 means sel is driven 0 = selected.
- clk  in  1  system clock (50 MHz). One clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- data_in  in  4*DIGITS  hex nibble per digit; digit i = data_in[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point per digit.
- blank_in  in  DIGITS  force digit dark.
- load_valid  in  1  data_in/dp_in/blank_in valid.
- load_ready  out  1  shadow buffer can accept.
- lzb_en  in  1  leading-zero blanking enable (level, sampled live).
- brightness  in  BRIGHT_W  duty level; all-ones = 100 %.
- seg  out  7  segments {a,b,c,d,e,f,g} = seg[6:0].
- dp  out  1  decimal point segment.
- sel  out  DIGITS  digit select; sel[i] drives digit i.
- frame_start  out  1  one-cycle pulse at start of each scan frame.

## Operation
- Counters: scan_cnt 0..SCAN_DIV-1; slot 0..DIGITS-1 advances when scan_cnt == SCAN_DIV-1; slot DIGITS-1 wraps to 0 (frame boundary).
- FSM: LAMP_TEST -> RUN. After reset, LAMP_TEST holds for exactly one frame: every digit shows all seven segments plus dp lit at full brightness. At the first frame boundary it moves to RUN permanently.
- Buffers: pending (shadow) and active registers, each holding nibbles, dp and blank. Both reset to zero. pend_full resets to 0.
- Handshake: load_ready = !pend_full || commit. A transfer is load_valid && load_ready. It captures into pending and sets pend_full. load_valid may stay high; extra transfers while ready overwrite pending (last wins).
- Commit: at a frame boundary in RUN with pend_full, pending is copied to active and pend_full clears. A transfer in the same cycle refills pending and leaves pend_full=1. LAMP_TEST never commits; loads during it are held in pending.
- Leading-zero blanking when lzb_en=1: digit i is suppressed if it and all higher digits have nibble 0 and dp 0. Digit 0 is never suppressed.
- Dark digit: blank bit or suppression drives seg and dp inactive while sel remains active.
- PWM: lit phase when scan_cnt[top BRIGHT_W bits] <= brightness. In the off phase, sel is all inactive. brightness = 2**BRIGHT_W-1 gives full duty.
- Decode: standard hex glyphs 0-9, A, b, C, d, E, F.

## Timing
- seg, dp, sel and frame_start are registered: 1-cycle latency from counter/slot state to pins.
- Reset values: seg all-unlit, dp unlit, sel all-deselected (polarity-adjusted), frame_start 0, load_ready 1.
- First lit output appears 1 cycle after rst_n deasserts, showing LAMP_TEST on digit 0.
- frame_start is high for the cycle when registered outputs first show slot 0. It also fires for the LAMP_TEST frame.
- Committed data is visible on the first slot-0 output after the boundary, never mid-frame.
- rst_n asserted mid-frame: everything returns immediately to reset values, pending data is lost, and LAMP_TEST repeats.
- brightness and lzb_en changes take effect on the next cycle, mid-slot.

## Structure
- Shared package seg7_pkg: glyph constant array (16 × 7 bits, active-high), lamp-test pattern, FSM state typedef.
- One sub-module, seg7_glyph_dec: combinational nibble->active-high glyph. Polarity inversion is applied only in the top level's output register.

## Test plan
Bench parameters: DIGITS=6, SCAN_DIV=16, BRIGHT_W=2, both polarities low.
- Reset release -> first 96 cycles: each digit shows seg=0000000, dp=0 in turn, sel walks 111110 ... 011111. frame_start pulses at cycles 1 and 97.
- Load 0x00A5C3 with no dp and no blanks during LAMP_TEST -> frame 2 shows C,3 on digits 1,0 and A,5 on digits 3,2; load_ready is 0 from after the load until the boundary.
- Same data with lzb_en=1 -> digits 5,4 dark (seg=1111111, sel active). Set dp_in[4] -> digit 4 shows 0 with dp lit.
- brightness=1 -> sel active for scan_cnt 0..7 of each slot, all 1s for 8..15. brightness=3 -> active for all 16.
- Back-to-back loads X then Y mid-frame, then Z in the boundary cycle -> active=Y at the boundary, pending=Z, load_ready 0 until the next boundary.
- rst_n pulse at slot 3, cycle 7 -> outputs go to reset values asynchronously; LAMP_TEST restarts from digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller: glyph table,
// lamp-test pattern and scan FSM states.
package seg7_pkg;

    typedef enum logic {
        ST_LAMP_TEST = 1'b0,
        ST_RUN       = 1'b1
    } scan_state_e;

    // Active-high {a,b,c,d,e,f,g}, index = hex nibble
    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    localparam logic [6:0] LAMP_SEG = 7'h7F;
    localparam logic       LAMP_DP  = 1'b1;

endpackage

// File: rtl/seg7_glyph_dec.sv
// Hex nibble to active-high seven-segment glyph; polarity is applied by the caller.
module seg7_glyph_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = GLYPH[nib_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous shadow
// buffer, leading-zero blanking, PWM brightness and a one-frame lamp test.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 6,
    parameter int SCAN_DIV       = 65536,
    parameter int BRIGHT_W       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  lzb_en,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_start
);

    localparam int               CNT_W     = $clog2(SCAN_DIV);
    localparam int               SLOT_W    = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);

    logic [CNT_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    scan_state_e         state_q, state_d;
    logic                slot_end, frame_end, lamp_on;

    logic [4*DIGITS-1:0] pend_nib_q, act_nib_q;
    logic [DIGITS-1:0]   pend_dp_q, pend_blank_q, act_dp_q, act_blank_q;
    logic                pend_full_q, pend_full_d;
    logic                commit, xfer;

    logic [DIGITS-1:0]   sel_hot, dark;
    logic                zero_run, bright_lit;
    logic [3:0]          cur_nib;
    logic [6:0]          cur_glyph, seg_hi;
    logic                dp_hi;
    logic [DIGITS-1:0]   sel_hi;

    logic [6:0]          seg_q;
    logic                dp_q, frame_start_q;
    logic [DIGITS-1:0]   sel_q;

    assign slot_end  = (scan_cnt_q == CNT_LAST);
    assign frame_end = slot_end && (slot_q == SLOT_LAST);

    always_comb begin
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        slot_d     = slot_q;
        if (slot_end) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
        end
    end

    // Scan FSM: state register / next state / output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_LAMP_TEST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_LAMP_TEST && frame_end) state_d = ST_RUN;
    end

    always_comb begin
        lamp_on = (state_q == ST_LAMP_TEST);
    end

    // A load held during lamp test commits at the boundary that enters RUN
    assign commit      = frame_end && pend_full_q && (state_d == ST_RUN);
    assign load_ready  = !pend_full_q || commit;
    assign xfer        = load_valid && load_ready;
    assign pend_full_d = xfer ? 1'b1 : (commit ? 1'b0 : pend_full_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q   <= '0;
            slot_q       <= '0;
            pend_nib_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_full_q  <= 1'b0;
            act_nib_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            slot_q      <= slot_d;
            pend_full_q <= pend_full_d;
            if (xfer) begin
                pend_nib_q   <= data_in;
                pend_dp_q    <= dp_in;
                pend_blank_q <= blank_in;
            end
            if (commit) begin
                act_nib_q   <= pend_nib_q;
                act_dp_q    <= pend_dp_q;
                act_blank_q <= pend_blank_q;
            end
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
        assign sel_hot[gi] = (slot_q == SLOT_W'(gi));
    end

    // zero_run tracks "this digit and everything above is a bare zero"
    always_comb begin
        dark     = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_nib_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
            dark[i]  = act_blank_q[i] || (lzb_en && (i != 0) && zero_run);
        end
    end

    assign cur_nib    = act_nib_q[{slot_q, 2'b00} +: 4];
    assign bright_lit = (scan_cnt_q[CNT_W-1 -: BRIGHT_W] <= brightness);

    seg7_glyph_dec u_glyph_dec (
        .nib_i   (cur_nib),
        .glyph_o (cur_glyph)
    );

    always_comb begin
        seg_hi = cur_glyph;
        dp_hi  = act_dp_q[slot_q];
        sel_hi = sel_hot & {DIGITS{bright_lit}};
        if (dark[slot_q]) begin
            seg_hi = '0;
            dp_hi  = 1'b0;
        end
        if (lamp_on) begin
            seg_hi = LAMP_SEG;
            dp_hi  = LAMP_DP;
            sel_hi = sel_hot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q         <= {7{SEG_ACTIVE_LOW}};
            dp_q          <= SEG_ACTIVE_LOW;
            sel_q         <= {DIGITS{SEL_ACTIVE_LOW}};
            frame_start_q <= 1'b0;
        end else begin
            seg_q         <= {7{SEG_ACTIVE_LOW}} ^ seg_hi;
            dp_q          <= SEG_ACTIVE_LOW ^ dp_hi;
            sel_q         <= {DIGITS{SEL_ACTIVE_LOW}} ^ sel_hi;
            frame_start_q <= (scan_cnt_q == '0) && (slot_q == '0);
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign sel         = sel_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: DIGITS=6, SCAN_DIV=16, BRIGHT_W=2, active-low pins.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] data_in;
    logic [5:0]  dp_in, blank_in;
    logic        load_valid, load_ready, lzb_en;
    logic [1:0]  brightness;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  sel;
    logic        frame_start;

    seg7_scan_ctrl #(
        .DIGITS         (6),
        .SCAN_DIV       (16),
        .BRIGHT_W       (2),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .lzb_en      (lzb_en),
        .brightness  (brightness),
        .seg         (seg),
        .dp          (dp),
        .sel         (sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; output at cycle k reflects counter value k-1
    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int         cyc;
        int         kind;   // 0: pins, 1: load_ready
        string      name;
        logic [6:0] seg;
        logic       dp;
        logic [5:0] sel;
        logic       fs;
        logic       lr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic exp_pins(input int c, input string n, input logic [6:0] s,
                            input logic d, input logic [5:0] sl, input logic f);
        exp_t e;
        e.cyc = c; e.kind = 0; e.name = n; e.seg = s; e.dp = d; e.sel = sl; e.fs = f; e.lr = 1'b0;
        sb.push_back(e);
    endtask

    task automatic exp_digit(input int c, input string n, input int d,
                             input logic [6:0] s, input logic dpv, input logic f);
        logic [5:0] one;
        one = 6'b000001;
        exp_pins(c, n, s, dpv, ~(one << d), f);
    endtask

    task automatic exp_lr(input int c, input string n, input logic r);
        exp_t e;
        e.cyc = c; e.kind = 1; e.name = n; e.seg = '0; e.dp = 1'b0; e.sel = '0; e.fs = 1'b0; e.lr = r;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due at the current cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (sb[i].kind == 0) begin
                    if ({seg, dp, sel, frame_start} !== {sb[i].seg, sb[i].dp, sb[i].sel, sb[i].fs}) begin
                        errors++;
                        $display("FAIL %s cyc=%0d: got seg=%b dp=%b sel=%b fs=%b, want seg=%b dp=%b sel=%b fs=%b",
                                 sb[i].name, cyc, seg, dp, sel, frame_start,
                                 sb[i].seg, sb[i].dp, sb[i].sel, sb[i].fs);
                    end else begin
                        $display("ok   %s cyc=%0d seg=%b dp=%b sel=%b fs=%b",
                                 sb[i].name, cyc, seg, dp, sel, frame_start);
                    end
                end else begin
                    if (load_ready !== sb[i].lr) begin
                        errors++;
                        $display("FAIL %s cyc=%0d: got load_ready=%b, want %b",
                                 sb[i].name, cyc, load_ready, sb[i].lr);
                    end else begin
                        $display("ok   %s cyc=%0d load_ready=%b", sb[i].name, cyc, load_ready);
                    end
                end
                sb.delete(i);
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    task automatic do_load(input int at, input logic [23:0] d,
                           input logic [5:0] p, input logic [5:0] b);
        wait_cyc(at);
        data_in    = d;
        dp_in      = p;
        blank_in   = b;
        load_valid = 1'b1;
        wait_cyc(at + 1);
        load_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] f2 [6];
        rst_n      = 1'b0;
        load_valid = 1'b0;
        data_in    = '0;
        dp_in      = '0;
        blank_in   = '0;
        lzb_en     = 1'b0;
        brightness = 2'd3;

        exp_pins(0, "reset_pins", 7'h7F, 1'b1, 6'h3F, 1'b0);
        exp_lr(0, "reset_ready", 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Lamp test frame: all segments and dp lit, select walks digits
        for (int d = 0; d < 6; d++) exp_digit(1 + 16*d, "lamp", d, 7'h00, 1'b0, d == 0);

        // Handshake around the load held through lamp test
        exp_lr(21, "ready_after_load", 1'b0);
        exp_lr(60, "ready_mid_lamp", 1'b0);
        exp_lr(94, "ready_before_bnd", 1'b0);
        exp_lr(95, "ready_commit", 1'b1);
        exp_lr(96, "ready_after_commit", 1'b1);

        // Frame 2: 0x00A5C3 -> 3, C, 5, A, 0, 0
        f2 = '{7'h06, 7'h31, 7'h24, 7'h08, 7'h01, 7'h01};
        for (int d = 0; d < 6; d++) exp_digit(97 + 16*d, "frame2", d, f2[d], 1'b1, d == 0);

        // Frame 3: leading-zero blanking darkens digits 5,4
        exp_digit(241, "lzb_d3", 3, 7'h08, 1'b1, 1'b0);
        exp_digit(257, "lzb_d4_dark", 4, 7'h7F, 1'b1, 1'b0);
        exp_digit(273, "lzb_d5_dark", 5, 7'h7F, 1'b1, 1'b0);

        // Frame 4: brightness=1 on digit 0, then dp on digit 4
        exp_pins(289, "pwm_s0", 7'h06, 1'b1, 6'b111110, 1'b1);
        exp_pins(296, "pwm_s7", 7'h06, 1'b1, 6'b111110, 1'b0);
        exp_pins(297, "pwm_s8_off", 7'h06, 1'b1, 6'b111111, 1'b0);
        exp_pins(304, "pwm_s15_off", 7'h06, 1'b1, 6'b111111, 1'b0);
        exp_pins(320, "pwm_full_s15", 7'h31, 1'b1, 6'b111101, 1'b0);
        exp_digit(353, "dp_d4", 4, 7'h01, 1'b0, 1'b0);
        exp_digit(369, "lzb_d5_still", 5, 7'h7F, 1'b1, 1'b0);

        // Frame 5 shows X = 0x123456; Y loaded mid-frame stays pending
        exp_digit(385, "x_d0", 0, 7'h20, 1'b1, 1'b1);
        exp_lr(420, "ready_y_pending", 1'b0);
        exp_digit(465, "x_d5_no_tear", 5, 7'h4F, 1'b1, 1'b0);
        exp_lr(479, "ready_bnd_z", 1'b1);
        exp_lr(480, "ready_z_pending", 1'b0);
        exp_lr(560, "ready_z_mid", 1'b0);
        exp_lr(575, "ready_bnd2", 1'b1);

        // Frame 6 shows Y = 0x789ABC with digit 2 blanked
        exp_digit(481, "y_d0", 0, 7'h31, 1'b1, 1'b1);
        exp_digit(513, "y_d2_blank", 2, 7'h7F, 1'b1, 1'b0);
        exp_digit(561, "y_d5", 5, 7'h0F, 1'b1, 1'b0);

        // Frame 7 shows Z = 0xDEF012 with dp on digit 0
        exp_digit(577, "z_d0_dp", 0, 7'h12, 1'b0, 1'b1);
        exp_digit(609, "z_d2_inner_zero", 2, 7'h01, 1'b1, 1'b0);
        exp_digit(625, "z_d3", 3, 7'h38, 1'b1, 1'b0);

        do_load(20, 24'h00A5C3, 6'b000000, 6'b000000);
        wait_cyc(185);
        lzb_en = 1'b1;
        do_load(200, 24'h00A5C3, 6'b010000, 6'b000000);
        wait_cyc(280);
        brightness = 2'd1;
        wait_cyc(310);
        brightness = 2'd3;
        do_load(330, 24'h123456, 6'b000000, 6'b000000);
        do_load(400, 24'h789ABC, 6'b000000, 6'b000100);
        do_load(479, 24'hDEF012, 6'b000001, 6'b000000);
        do_load(620, 24'h999999, 6'b000000, 6'b000000);

        // Asynchronous reset at slot 3, scan 7 with a load pending
        wait_cyc(631);
        exp_pins(0, "async_reset_pins", 7'h7F, 1'b1, 6'h3F, 1'b0);
        exp_lr(0, "async_reset_ready", 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        lzb_en = 1'b0;
        rst_n  = 1'b1;

        exp_digit(1, "relamp_d0", 0, 7'h00, 1'b0, 1'b1);
        exp_lr(1, "relamp_ready", 1'b1);
        exp_digit(49, "relamp_d3", 3, 7'h00, 1'b0, 1'b0);
        exp_digit(97, "lost_pend_d0", 0, 7'h01, 1'b1, 1'b1);
        exp_digit(145, "lost_pend_d3", 3, 7'h01, 1'b1, 1'b0);

        wait_cyc(150);
        @(negedge clk);
        #1;
        foreach (sb[i]) begin
            errors++;
            checks++;
            $display("FAIL %s: expectation for cyc=%0d never checked", sb[i].name, sb[i].cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
